// File: rtl/cmd_scheduler.sv
// Paces decoded IR commands: queues receiver pushes and issues them with a minimum idle gap.
// Optional repeat suppression of identical commands is built when CMD_REPEAT_FILTER_EN is defined.
module cmd_scheduler #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned GAP_CYCLES     = 1000,
   parameter int unsigned HOLDOFF_CYCLES = 5000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [11:0]              data,
   input  logic                     data_rdy,
   output logic [11:0]              cmd_out,
   output logic                     cmd_valid,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_param_check
      $error("cmd_scheduler: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t          state, state_next;
   logic [11:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [GW-1:0]   gap_cnt, gap_next;
   logic            prev_rdy;
   logic            push, pop, accept, drop, suppress, valid_next;

   assign push   = data_rdy & ~prev_rdy;
   assign accept = push & ~suppress & ((fifo_count != CW'(DEPTH)) | pop);
   assign drop   = push & ~suppress & (fifo_count == CW'(DEPTH)) & ~pop;

`ifdef CMD_REPEAT_FILTER_EN
   localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);

   logic [HW-1:0] holdoff_cnt;
   logic [11:0]   last_cmd;
   logic          last_vld;

   assign suppress = push & last_vld & (data == last_cmd) & (holdoff_cnt != '0);

   // Holdoff window restarts on every push that is either queued or suppressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdoff_cnt <= '0;
         last_cmd    <= '0;
         last_vld    <= 1'b0;
      end else begin
         if (accept | suppress)
            holdoff_cnt <= HW'(HOLDOFF_CYCLES);
         else if (holdoff_cnt != '0)
            holdoff_cnt <= holdoff_cnt - HW'(1);
         if (accept) begin
            last_cmd <= data;
            last_vld <= 1'b1;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Gap counter leaves GAP when it decrements to zero, giving GAP_CYCLES+1 issue spacing.
   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      pop        = 1'b0;
      valid_next = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop        = 1'b1;
               valid_next = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            gap_next   = GW'(GAP_CYCLES - 1);
            state_next = GAP;
         end
         GAP: begin
            if (gap_cnt <= GW'(1)) begin
               gap_next   = '0;
               state_next = IDLE;
            end else begin
               gap_next = gap_cnt - GW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_rdy   <= 1'b0;
         cmd_out    <= 12'h000;
         cmd_valid  <= 1'b0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         gap_cnt    <= '0;
      end else begin
         prev_rdy   <= data_rdy;
         cmd_valid  <= valid_next;
         gap_cnt    <= gap_next;
         fifo_count <= fifo_count + CW'(accept) - CW'(pop);
         if (pop) begin
            cmd_out <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (drop)   overflow <= 1'b1;
      end
   end

   // Storage needs no reset; a full-FIFO write lands in the slot being popped the same edge.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= data;
   end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: two instances (short gap with holdoff 50, long gap for overflow).
module tb_cmd_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rdy_a, val_a, ovf_a;
   logic [11:0] data_a, cmd_a;
   logic [2:0]  cnt_a;
   logic        rst_b, rdy_b, val_b, ovf_b;
   logic [11:0] data_b, cmd_b;
   logic [2:0]  cnt_b;

   cmd_scheduler #(.DEPTH(4), .GAP_CYCLES(4), .HOLDOFF_CYCLES(50)) dut_a (
      .clk(clk), .rst(rst_a), .data(data_a), .data_rdy(rdy_a),
      .cmd_out(cmd_a), .cmd_valid(val_a), .fifo_count(cnt_a), .overflow(ovf_a));

   cmd_scheduler #(.DEPTH(4), .GAP_CYCLES(100), .HOLDOFF_CYCLES(50)) dut_b (
      .clk(clk), .rst(rst_b), .data(data_b), .data_rdy(rdy_b),
      .cmd_out(cmd_b), .cmd_valid(val_b), .fifo_count(cnt_b), .overflow(ovf_b));

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int push_cyc;
   int pa_cyc[$], pa_cmd[$], pb_cyc[$], pb_cmd[$];
   int exp_cmds[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Log every issued pulse with the cycle index it was visible in.
   always @(posedge clk) begin
      if (val_a === 1'b1) begin pa_cyc.push_back(cyc); pa_cmd.push_back(int'(cmd_a)); end
      if (val_b === 1'b1) begin pb_cyc.push_back(cyc); pb_cmd.push_back(int'(cmd_b)); end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic push_a(input logic [11:0] d);
      data_a = d; rdy_a = 1'b1; tick(1);
      push_cyc = cyc;
      rdy_a = 1'b0; tick(1);
   endtask

   task automatic push_b(input logic [11:0] d);
      data_b = d; rdy_b = 1'b1; tick(1);
      push_cyc = cyc;
      rdy_b = 1'b0; tick(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_a = 1'b1; rdy_a = 1'b0; data_a = '0;
      rst_b = 1'b1; rdy_b = 1'b0; data_b = '0;
      tick(2);
      chk("reset_cmd_out", 32'(cmd_a), 0);
      chk("reset_cmd_valid", 32'(val_a), 0);
      chk("reset_fifo_count", 32'(cnt_a), 0);
      chk("reset_overflow", 32'(ovf_a), 0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick(2);

      // Single command latency
      pa_cyc.delete(); pa_cmd.delete();
      data_a = 12'h0A5; rdy_a = 1'b1; tick(1);
      c0 = cyc;
      chk("single_count_after_push", 32'(cnt_a), 1);
      chk("single_no_bypass", 32'(val_a), 0);
      rdy_a = 1'b0; tick(1);
      chk("single_valid", 32'(val_a), 1);
      chk("single_cmd", 32'(cmd_a), 32'h0A5);
      chk("single_count_after_pop", 32'(cnt_a), 0);
      tick(1);
      chk("single_valid_drop", 32'(val_a), 0);
      chk("single_cmd_held", 32'(cmd_a), 32'h0A5);
      tick(10);
      chk("single_pulses", 32'(pa_cyc.size()), 1);
      chk("single_latency", 32'(qget(pa_cyc, 0) - c0), 1);

      // Back-to-back pushes, including a push coinciding with a pop
      pa_cyc.delete(); pa_cmd.delete();
      push_a(12'h001);
      c0 = push_cyc;
      push_a(12'h002);
      push_a(12'h003);
      push_a(12'h004);
      chk("burst_count_push_pop", 32'(cnt_a), 2);
      tick(20);
      chk("burst_pulses", 32'(pa_cmd.size()), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("burst_cmd%0d", i), 32'(qget(pa_cmd, i)), 32'(i + 1));
      chk("burst_first_latency", 32'(qget(pa_cyc, 0) - c0), 1);
      for (int i = 1; i < 4; i++) chk($sformatf("burst_spacing%0d", i), 32'(qget(pa_cyc, i) - qget(pa_cyc, i - 1)), 5);
      chk("burst_count_end", 32'(cnt_a), 0);

      // Level held high is a single push
      pa_cyc.delete(); pa_cmd.delete();
      data_a = 12'h3C3; rdy_a = 1'b1; tick(1000);
      rdy_a = 1'b0; tick(10);
      chk("level_pulses", 32'(pa_cmd.size()), 1);
      chk("level_cmd", 32'(qget(pa_cmd, 0)), 32'h3C3);
      chk("level_count", 32'(cnt_a), 0);

      // Repeat filter window (suppression only when the filter is built)
      pa_cyc.delete(); pa_cmd.delete();
      push_a(12'h10C);
      tick(18);
      push_a(12'h10C);
      tick(60);
      push_a(12'h10C);
      push_a(12'h2D2);
      tick(20);
`ifdef CMD_REPEAT_FILTER_EN
      exp_cmds = '{32'h10C, 32'h10C, 32'h2D2};
`else
      exp_cmds = '{32'h10C, 32'h10C, 32'h10C, 32'h2D2};
`endif
      chk("filter_pulses", 32'(pa_cmd.size()), 32'(exp_cmds.size()));
      for (int i = 0; i < exp_cmds.size(); i++) chk($sformatf("filter_cmd%0d", i), 32'(qget(pa_cmd, i)), 32'(exp_cmds[i]));
      chk("filter_no_overflow", 32'(ovf_a), 0);

      // Reset mid-GAP with two queued
      push_a(12'h011);
      push_a(12'h022);
      data_a = 12'h033; rdy_a = 1'b1; tick(1);
      chk("midgap_count", 32'(cnt_a), 2);
      rst_a = 1'b1; rdy_a = 1'b0;
      #1;
      chk("midgap_rst_cmd", 32'(cmd_a), 0);
      chk("midgap_rst_valid", 32'(val_a), 0);
      chk("midgap_rst_count", 32'(cnt_a), 0);
      chk("midgap_rst_overflow", 32'(ovf_a), 0);
      tick(3);
      pa_cyc.delete(); pa_cmd.delete();
      rst_a = 1'b0;
      tick(20);
      chk("midgap_no_pulse", 32'(pa_cmd.size()), 0);
      chk("midgap_count_after", 32'(cnt_a), 0);

      // data_rdy high at reset release pushes on the first edge
      rst_a = 1'b1; data_a = 12'h055; rdy_a = 1'b1;
      tick(2);
      rst_a = 1'b0;
      tick(1);
      chk("release_push_count", 32'(cnt_a), 1);
      rdy_a = 1'b0;
      tick(10);
      chk("release_pulses", 32'(pa_cmd.size()), 1);
      chk("release_cmd", 32'(qget(pa_cmd, 0)), 32'h055);

      // Overflow during a long gap, then a push at full with a pop
      pb_cyc.delete(); pb_cmd.delete();
      push_b(12'h0B0);
      c0 = push_cyc;
      for (int i = 1; i <= 6; i++) push_b(12'h0B0 + 12'(i));
      chk("ovf_count_full", 32'(cnt_b), 4);
      chk("ovf_flag", 32'(ovf_b), 1);
      while (cyc < c0 + 101) tick(1);
      data_b = 12'h0B7; rdy_b = 1'b1; tick(1);
      chk("full_push_pop_count", 32'(cnt_b), 4);
      rdy_b = 1'b0;
      while (cyc < c0 + 520) tick(1);
      exp_cmds = '{32'h0B0, 32'h0B1, 32'h0B2, 32'h0B3, 32'h0B4, 32'h0B7};
      chk("ovf_pulses", 32'(pb_cmd.size()), 6);
      for (int i = 0; i < 6; i++) chk($sformatf("ovf_cmd%0d", i), 32'(qget(pb_cmd, i)), 32'(exp_cmds[i]));
      chk("ovf_spacing", 32'(qget(pb_cyc, 1) - qget(pb_cyc, 0)), 101);
      chk("ovf_count_end", 32'(cnt_b), 0);
      chk("ovf_sticky", 32'(ovf_b), 1);
      rst_b = 1'b1;
      #1;
      chk("ovf_cleared_by_rst", 32'(ovf_b), 0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
